// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types and default constants for the guess sequencer
//
// Holds the sequencer state encoding and the default values of the
// MAX_TRIES and DEB_CYCLES parameters used by guess_sequencer and
// enter_debounce.
package guess_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM_REL = 3'd1,
        S_GUESS   = 3'd2,
        S_HOLD    = 3'd3,
        S_EVAL    = 3'd4,
        S_WIN     = 3'd5,
        S_LOSE    = 3'd6
    } state_t;

    localparam int MAX_TRIES_DEF  = 8;
    localparam int DEB_CYCLES_DEF = 50000;

endpackage

// File: rtl/enter_debounce.sv
// rtl/enter_debounce.sv - level debounce filter for the synchronized enter button
//
// Purpose: accepts a new input level only after it has been stable for
// DEB_CYCLES consecutive clk cycles; shorter excursions are discarded.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset (clears level and counter)
//   i_din    already-synchronized raw level
//   o_level  filtered (accepted) level, registered
module enter_debounce
    import guess_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_level
);

    localparam int            CW       = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;

    // The counter runs only while the input disagrees with the accepted
    // level; any return to the accepted level restarts the qualification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_din == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= i_din;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/guess_sequencer.sv
// rtl/guess_sequencer.sv - control FSM for the number-guessing game
//
// Purpose: sequences start press, guesses, evaluation and win/lose result
// for a guessing-game datapath. Optional debounce of i_enter is compiled in
// when the macro GUESS_DEBOUNCE_EN is defined.
// Ports:
//   clk            system clock (rising edge)
//   reset          asynchronous active-high reset
//   i_enter        raw push-button, asynchronous to clk
//   i_new_game     synchronous abandon-and-restart request
//   i_over/i_under/i_equal  one-hot compare flags from the datapath
//   o_inc_actual   advance the random target counter (idle only)
//   o_update_leds  copy compare flags to LEDs (evaluation cycle)
//   o_tries_left   guesses remaining
//   o_win/o_lose   held game-result indicators
module guess_sequencer
    import guess_pkg::*;
#(
    parameter int MAX_TRIES  = MAX_TRIES_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enter,
    input  logic       i_new_game,
    input  logic       i_over,
    input  logic       i_under,
    input  logic       i_equal,
    output logic       o_inc_actual,
    output logic       o_update_leds,
    output logic [3:0] o_tries_left,
    output logic       o_win,
    output logic       o_lose
);

    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);

    logic [1:0] r_sync;
    logic       r_level_q;
    logic [3:0] r_tries;
    state_t     r_state;

    logic       w_level;
    logic       w_press;
    logic       w_release;
    state_t     w_next_state;
    logic [3:0] w_tries_next;
    logic       w_unused_flags;

    // Only equality steers the FSM; over/under are consumed by the LED path.
    assign w_unused_flags = i_over ^ i_under;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_enter};
        end
    end

`ifdef GUESS_DEBOUNCE_EN
    enter_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_enter_debounce (
        .clk     (clk),
        .reset   (reset),
        .i_din   (r_sync[1]),
        .o_level (w_level)
    );
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_CYCLES > 0);
    assign w_level      = r_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= w_level;
        end
    end

    assign w_press   =  w_level & ~r_level_q;
    assign w_release = ~w_level &  r_level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tries <= TRIES_INIT;
        end else begin
            r_state <= w_next_state;
            r_tries <= w_tries_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tries_next = r_tries;
        case (r_state)
            S_IDLE:    if (w_press)   w_next_state = S_ARM_REL;
            S_ARM_REL: if (w_release) w_next_state = S_GUESS;
            S_GUESS:   if (w_press)   w_next_state = S_HOLD;
            S_HOLD:    if (w_release) w_next_state = S_EVAL;
            S_EVAL: begin
                w_tries_next = (r_tries != 4'd0) ? r_tries - 4'd1 : 4'd0;
                // A correct guess wins even when it uses the last try.
                if (i_equal)
                    w_next_state = S_WIN;
                else if (r_tries <= 4'd1)
                    w_next_state = S_LOSE;
                else
                    w_next_state = S_GUESS;
            end
            S_WIN:     w_next_state = S_WIN;
            S_LOSE:    w_next_state = S_LOSE;
            default:   w_next_state = S_IDLE;
        endcase
        // Restart request overrides any button event seen in the same cycle.
        if (i_new_game && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_tries_next = TRIES_INIT;
        end
    end

    assign o_inc_actual  = (r_state == S_IDLE);
    assign o_update_leds = (r_state == S_EVAL);
    assign o_win         = (r_state == S_WIN);
    assign o_lose        = (r_state == S_LOSE);
    assign o_tries_left  = r_tries;

endmodule
